// File: rtl/quad_decoder_if.sv
// Quadrature decoder bus interface.
// Bundles the encoder-side inputs and the position/status outputs of
// quad_decoder so the block can be dropped between encoder pins and the
// position consumers with a single port.
//   i_a_in  raw encoder phase A (asynchronous)
//   i_b_in  raw encoder phase B (asynchronous)
//   i_clr   synchronous clear of position and error
//   o_pos   wrapping position count (WIDTH bits)
//   o_dir   direction of last accepted step (1 up, 0 down)
//   o_step  one-clock pulse per accepted step
//   o_wrap  one-clock pulse when the position wraps
//   o_err   sticky illegal-transition flag
// master: the side driving the encoder inputs; slave: the decoder itself.
interface quad_decoder_if #(
  parameter int WIDTH = 16
);
  logic             i_a_in;
  logic             i_b_in;
  logic             i_clr;
  logic [WIDTH-1:0] o_pos;
  logic             o_dir;
  logic             o_step;
  logic             o_wrap;
  logic             o_err;

  modport master (
    output i_a_in, i_b_in, i_clr,
    input  o_pos, o_dir, o_step, o_wrap, o_err
  );

  modport slave (
    input  i_a_in, i_b_in, i_clr,
    output o_pos, o_dir, o_step, o_wrap, o_err
  );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature (A/B) encoder front end.
// Synchronises and glitch-filters the two raw encoder phases, decodes the
// Gray-code transitions into up/down steps and keeps a wrapping position.
//   clk    clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    quad_decoder_if.slave: i_a_in/i_b_in/i_clr in,
//          o_pos/o_dir/o_step/o_wrap/o_err out
// Parameters: WIDTH position width, FILT clocks a synchronised phase must
// hold a new level before it is accepted (>=1).
module quad_decoder #(
  parameter int WIDTH = 16,
  parameter int FILT  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  quad_decoder_if.slave  bus
);

  localparam int            CW      = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT - 1);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  // Phase vectors are packed as {A,B}.
  logic [1:0]       r_syncMeta;
  logic [1:0]       r_syncOut;
  logic [1:0]       r_filt;
  logic [CW-1:0]    r_cnt [2];
  logic [1:0]       r_prev;
  logic [WIDTH-1:0] r_pos;
  logic             r_dir;
  logic             r_step;
  logic             r_wrap;
  logic             r_err;
  state_t           r_state;
  logic [1:0]       r_initCnt;

  state_t           w_nextState;
  logic [1:0]       w_nextInitCnt;
  logic             w_run;
  logic [1:0]       w_diff;
  logic             w_single;
  logic             w_illegal;
  logic             w_up;
  logic             w_down;

  // Two-flop synchroniser for both phases.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_syncMeta <= '0;
      r_syncOut  <= '0;
    end else begin
      r_syncMeta <= {bus.i_a_in, bus.i_b_in};
      r_syncOut  <= r_syncMeta;
    end
  end

  // Init window state register: three edges after reset release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_INIT;
      r_initCnt <= '0;
    end else begin
      r_state   <= w_nextState;
      r_initCnt <= w_nextInitCnt;
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_nextInitCnt = r_initCnt;
    w_run         = 1'b0;
    case (r_state)
      S_INIT: begin
        w_nextInitCnt = r_initCnt + 2'd1;
        if (r_initCnt == 2'd2) begin
          w_nextState   = S_RUN;
          w_nextInitCnt = '0;
        end
      end
      S_RUN: begin
        w_run = 1'b1;
      end
      default: begin
        w_nextState = S_INIT;
      end
    endcase
  end

  // Glitch filter: a phase is accepted only after the synchronised level has
  // disagreed with the filtered level for FILT consecutive edges. During the
  // init window the filter simply follows the synchroniser.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_filt   <= '0;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else if (!w_run) begin
      r_filt   <= r_syncOut;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_syncOut[i] != r_filt[i]) begin
          if (r_cnt[i] == CNT_MAX) begin
            r_filt[i] <= r_syncOut[i];
            r_cnt[i]  <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CW'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // For a single-bit Gray change the move is "up" exactly when the old A
  // equals the new B (00->10, 10->11, 11->01, 01->00).
  always_comb begin
    w_diff    = r_prev ^ r_filt;
    w_single  = w_diff[1] ^ w_diff[0];
    w_illegal = w_run & w_diff[1] & w_diff[0];
    w_up      = w_run & w_single & (r_prev[1] == r_filt[0]);
    w_down    = w_run & w_single & (r_prev[1] != r_filt[0]);
  end

  // Decode and position register. Clear is applied last so that it wins over
  // a same-cycle count or error, while step/dir are still reported.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev <= '0;
      r_pos  <= '0;
      r_dir  <= 1'b0;
      r_step <= 1'b0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_step <= 1'b0;
      r_wrap <= 1'b0;
      if (!w_run) begin
        r_prev <= r_syncOut;
      end else begin
        r_prev <= r_filt;
        if (w_up || w_down) begin
          r_step <= 1'b1;
          r_dir  <= w_up;
          if (!bus.i_clr) begin
            if (w_up) begin
              r_pos  <= r_pos + WIDTH'(1);
              r_wrap <= &r_pos;
            end else begin
              r_pos  <= r_pos - WIDTH'(1);
              r_wrap <= ~|r_pos;
            end
          end
        end
        if (w_illegal) begin
          r_err <= 1'b1;
        end
      end
      if (bus.i_clr) begin
        r_pos <= '0;
        r_err <= 1'b0;
      end
    end
  end

  assign bus.o_pos  = r_pos;
  assign bus.o_dir  = r_dir;
  assign bus.o_step = r_step;
  assign bus.o_wrap = r_wrap;
  assign bus.o_err  = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// Testbench for quad_decoder (WIDTH=16, FILT=4).
// Drives the encoder pins cycle by cycle and compares every output on every
// clock against a behavioural model: a delay line for the synchroniser, a
// sliding window of recent samples for the filter and Gray-index arithmetic
// for decoding. Directed scenarios are followed by a randomised walk.
module tb_quad_decoder;

  localparam int WIDTH = 16;
  localparam int FILT  = 4;
  localparam int MODV  = 1 << WIDTH;

  logic clk;
  logic rst_n;

  quad_decoder_if #(.WIDTH(WIDTH)) bus ();

  quad_decoder #(.WIDTH(WIDTH), .FILT(FILT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;
  int cycleCount = 0;
  int stepCount = 0;
  int wrapCount = 0;
  int firstStep = -1;

  // Stimulus shadow, read by the model
  logic tbA, tbB, tbClr, tbRstn;
  logic [1:0] curAB;

  // Model state
  logic [1:0] mQ[$];
  logic [1:0] mHist[$];
  logic [1:0] mSync, mFilt, mPrev;
  int         mInitLeft;
  int         mPos;
  logic       mDir, mStep, mWrap, mErr;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed,
               expected, cycleCount);
    end
  endtask

  // Position of {A,B} along the up sequence 00->10->11->01
  function automatic int grayIdx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] grayAt(input int idx);
    case (idx % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic modelStep();
    logic [1:0] s;
    logic [1:0] nf;
    int d;
    bit allDiff;
    if (!tbRstn) begin
      mQ.delete();
      mQ.push_back(2'b00);
      mHist.delete();
      mSync = 2'b00; mFilt = 2'b00; mPrev = 2'b00;
      mInitLeft = 3;
      mPos = 0; mDir = 0; mStep = 0; mWrap = 0; mErr = 0;
      return;
    end
    s = mSync;
    mQ.push_back({tbA, tbB});
    mSync = mQ.pop_front();
    mStep = 0;
    mWrap = 0;
    mHist.push_back(s);
    if (mHist.size() > FILT) void'(mHist.pop_front());
    if (mInitLeft > 0) begin
      mInitLeft--;
      mFilt = s;
      mPrev = s;
    end else begin
      d = (grayIdx(mFilt) - grayIdx(mPrev) + 4) % 4;
      if (d == 1 || d == 3) begin
        mStep = 1;
        mDir  = (d == 1);
        if (!tbClr) begin
          if (d == 1) begin
            mWrap = (mPos == MODV - 1);
            mPos  = (mPos + 1) % MODV;
          end else begin
            mWrap = (mPos == 0);
            mPos  = (mPos + MODV - 1) % MODV;
          end
        end
      end else if (d == 2 && !tbClr) begin
        mErr = 1;
      end
      mPrev = mFilt;
      nf = mFilt;
      if (mHist.size() == FILT) begin
        for (int i = 0; i < 2; i++) begin
          allDiff = 1;
          foreach (mHist[k]) if (mHist[k][i] == mFilt[i]) allDiff = 0;
          if (allDiff) nf[i] = ~mFilt[i];
        end
      end
      mFilt = nf;
    end
    if (tbClr) begin
      mPos = 0;
      mErr = 0;
    end
  endtask

  // Hold the given inputs for n clocks, checking every output each clock.
  task automatic applyStimulus(input logic iA, input logic iB, input logic iClr,
                               input logic iRstn, input int n);
    for (int c = 0; c < n; c++) begin
      tbA = iA; tbB = iB; tbClr = iClr; tbRstn = iRstn;
      bus.i_a_in = iA;
      bus.i_b_in = iB;
      bus.i_clr  = iClr;
      rst_n      = iRstn;
      @(posedge clk);
      cycleCount++;
      modelStep();
      @(negedge clk);
      checkOutput("pos",  32'(bus.o_pos),  32'(mPos));
      checkOutput("dir",  32'(bus.o_dir),  32'(mDir));
      checkOutput("step", 32'(bus.o_step), 32'(mStep));
      checkOutput("wrap", 32'(bus.o_wrap), 32'(mWrap));
      checkOutput("err",  32'(bus.o_err),  32'(mErr));
      if (bus.o_step === 1'b1) begin
        stepCount++;
        if (firstStep < 0) firstStep = cycleCount;
      end
      if (bus.o_wrap === 1'b1) wrapCount++;
    end
  endtask

  task automatic moveTo(input logic [1:0] ab, input int hold);
    curAB = ab;
    applyStimulus(ab[1], ab[0], 1'b0, 1'b1, hold);
  endtask

  int startEdge;
  int posBefore;
  int r;
  int hold;
  logic [1:0] saved;

  initial begin
    // 1: reset with both phases high, no steps after init
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3);
    checkOutput("rst_pos", 32'(bus.o_pos), 32'd0);
    curAB = 2'b11;
    stepCount = 0;
    moveTo(2'b11, 20);
    checkOutput("t1_steps", 32'(stepCount), 32'd0);
    checkOutput("t1_err", 32'(bus.o_err), 32'd0);

    // 2: four full up cycles, 10 clocks per level
    stepCount = 0;
    firstStep = -1;
    startEdge = cycleCount + 1;
    for (int k = 0; k < 16; k++) moveTo(grayAt(grayIdx(curAB) + 1), 10);
    checkOutput("t2_steps", 32'(stepCount), 32'd16);
    checkOutput("t2_pos", 32'(bus.o_pos), 32'd16);
    checkOutput("t2_dir", 32'(bus.o_dir), 32'd1);
    checkOutput("t2_latency", 32'(firstStep - startEdge + 1), 32'd7);

    // 3: short and long A pulses from idle 00
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2);
    moveTo(2'b00, 20);
    posBefore = int'(bus.o_pos);
    stepCount = 0;
    moveTo(2'b10, 3);
    moveTo(2'b00, 20);
    checkOutput("t3_short_steps", 32'(stepCount), 32'd0);
    checkOutput("t3_short_pos", 32'(bus.o_pos), 32'(posBefore));
    moveTo(2'b10, 5);
    moveTo(2'b00, 20);
    checkOutput("t3_long_steps", 32'(stepCount), 32'd2);
    checkOutput("t3_long_pos", 32'(bus.o_pos), 32'(posBefore));
    checkOutput("t3_err", 32'(bus.o_err), 32'd0);

    // 4: wrap down from 0 and back up
    wrapCount = 0;
    moveTo(2'b01, 10);
    checkOutput("t4_down_pos", 32'(bus.o_pos), 32'hFFFF);
    checkOutput("t4_down_dir", 32'(bus.o_dir), 32'd0);
    checkOutput("t4_down_wrap", 32'(wrapCount), 32'd1);
    moveTo(2'b00, 10);
    checkOutput("t4_up_pos", 32'(bus.o_pos), 32'd0);
    checkOutput("t4_up_wrap", 32'(wrapCount), 32'd2);

    // 5: illegal transition, clear, clear coincident with a wrapping step
    moveTo(2'b10, 10);
    moveTo(2'b01, 12);
    checkOutput("t5_err", 32'(bus.o_err), 32'd1);
    checkOutput("t5_err_pos", 32'(bus.o_pos), 32'd1);
    moveTo(2'b01, 10);
    checkOutput("t5_err_sticky", 32'(bus.o_err), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1);
    checkOutput("t5_clr_pos", 32'(bus.o_pos), 32'd0);
    checkOutput("t5_clr_err", 32'(bus.o_err), 32'd0);
    moveTo(2'b01, 5);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 6);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1);
    curAB = 2'b11;
    checkOutput("t5_cs_step", 32'(bus.o_step), 32'd1);
    checkOutput("t5_cs_dir", 32'(bus.o_dir), 32'd0);
    checkOutput("t5_cs_pos", 32'(bus.o_pos), 32'd0);
    checkOutput("t5_cs_wrap", 32'(bus.o_wrap), 32'd0);
    moveTo(2'b11, 8);

    // 6: reset mid-sequence at pos=37
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2);
    moveTo(2'b00, 10);
    for (int k = 0; k < 37; k++) moveTo(grayAt(grayIdx(curAB) + 1), 6);
    moveTo(curAB, 4);
    checkOutput("t6_pos37", 32'(bus.o_pos), 32'd37);
    applyStimulus(curAB[1], curAB[0], 1'b0, 1'b0, 1);
    checkOutput("t6_rst_pos", 32'(bus.o_pos), 32'd0);
    checkOutput("t6_rst_dir", 32'(bus.o_dir), 32'd0);
    checkOutput("t6_rst_step", 32'(bus.o_step), 32'd0);
    moveTo(curAB, 10);
    firstStep = -1;
    startEdge = cycleCount + 1;
    moveTo(grayAt(grayIdx(curAB) + 1), 10);
    checkOutput("t6_latency", 32'(firstStep - startEdge + 1), 32'd7);
    checkOutput("t6_pos", 32'(bus.o_pos), 32'd1);

    // 7: randomised walk with glitches, illegal moves and clears
    for (int k = 0; k < 300; k++) begin
      r = int'($urandom_range(0, 99));
      hold = int'($urandom_range(2, 14));
      if (r < 70) begin
        if ($urandom_range(0, 1) == 1) moveTo(grayAt(grayIdx(curAB) + 1), hold);
        else moveTo(grayAt(grayIdx(curAB) + 3), hold);
      end else if (r < 82) begin
        saved = curAB;
        moveTo(curAB ^ (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01),
               int'($urandom_range(1, 3)));
        moveTo(saved, hold);
      end else if (r < 88) begin
        moveTo(curAB ^ 2'b11, hold);
      end else if (r < 96) begin
        applyStimulus(curAB[1], curAB[0], 1'b1, 1'b1, 1);
      end else begin
        applyStimulus(curAB[1], curAB[0], 1'b0, 1'b0, 1);
        moveTo(curAB, 4);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
